reg_file_mp: RTL and testbench
==============================

Name: reg_file_mp

Overview:
- Parametrised multi-port integer register file for the next-generation pipelined RISC-V core.
- Adds the following over the single-cycle register file:
  - N read ports and M write ports.
  - Hardwired-zero register 0.
  - Optional write-to-read bypass.
  - Per-register busy scoreboard for hazard detection.
  - Sequenced, counter-driven clear after reset, so the array maps to RAM-like storage with no bulk reset.
- Sits between decode (read and scoreboard-set) and writeback (write).

Parameters:
- XLEN, 32, data width in bits
- NREGS, 32, number of registers; power of 2, at least 2
- NRD, 2, number of read ports
- NWR, 2, number of write ports
- ZERO_REG, 1, 1 = register 0 reads as 0, ignores writes and is never busy
- BYPASS, 1, 1 = a read returns same-cycle write data when the address matches
- AW, $clog2(NREGS), address width (derived; not overridable)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- init_done  out  1  high once the clear sequence has finished; all other ports are ignored or forced while low
- rd_addr  in  NRD*AW  read addresses; port i occupies bits [i*AW +: AW]
- rd_data  out  NRD*XLEN  read data; combinational
- rd_busy  out  NRD  scoreboard busy flag for each read address; combinational
- wr_en  in  NWR  write enables
- wr_addr  in  NWR*AW  write addresses
- wr_data  in  NWR*XLEN  write data
- sb_set_en  in  1  mark a destination register pending (issue)
- sb_set_addr  in  AW  destination register to mark

Behaviour:
- Reset (synchronous, active-high; one clock, clk):
  - FSM goes to CLEAR, clear counter = 0, all busy bits = 0, init_done = 0.
  - Array contents are not reset directly.
- CLEAR state, each posedge with reset=0:
  - reg[cnt] <= 0, cnt <= cnt+1.
  - When cnt == NREGS-1, go to READY.
  - init_done is registered and rises at the NREGS-th posedge after reset deasserts.
- Behaviour during CLEAR:
  - wr_en and sb_set_en are ignored.
  - rd_data = 0 and rd_busy = 0 on every port.
- Reset asserted mid-CLEAR or in READY: back to CLEAR with cnt = 0; the full NREGS-cycle sequence restarts.
- READY write:
  - At posedge, for each port j with wr_en[j], reg[wr_addr[j]] <= wr_data[j].
  - Same-address multi-write: the highest-index port wins.
  - Address 0 writes are dropped when ZERO_REG=1.
- READY read (combinational), per read port:
  - If ZERO_REG and addr == 0, the result is 0.
  - Otherwise, if BYPASS and any enabled write port matches the address, the result is that port's data (highest index wins).
  - Otherwise, the result is reg[addr].
- Scoreboard, at posedge in READY:
  - A write to addr a clears busy[a].
  - sb_set_en sets busy[sb_set_addr].
  - Set and clear on the same address in the same cycle: set wins (a new producer has been issued).
  - busy[0] stays 0 when ZERO_REG=1.
- rd_busy[i]:
  - = busy[rd_addr[i]].
  - When BYPASS=1, it is forced to 0 if an enabled write that cycle matches rd_addr[i] and is not overridden by a same-cycle sb_set to that address. It also reads 0 for the zero register.
- Latency:
  - Write-to-read is 0 cycles with BYPASS, 1 cycle without.
  - Set-to-busy is 1 cycle.
- No X propagation: every output is driven in every state.

Decomposition:
- Package reg_file_pkg:
  - FSM state encoding (CLEAR, READY).
  - A helper function for port-slice indexing.
- Sub-module reg_sb:
  - NREGS-bit busy vector with set/clear priority and the per-port lookup.
  - Instantiated once.
- The storage array, clear FSM and bypass muxing remain in reg_file_mp.

Test Plan:
1. Clear sequence:
   - Stimulus: reset for 3 cycles, then release; NREGS=32.
   - Required response: init_done=0 for 31 posedges and 1 at the 32nd. During CLEAR, wr_en=1 to addr 5 with 0xDEAD is ignored. Afterwards, all 32 registers read 0.
2. Reset mid-clear:
   - Stimulus: assert reset at clear cycle 10.
   - Required response: after release, init_done again takes exactly 32 cycles; registers 0..31 read 0.
3. Write and read:
   - Stimulus: write 0xA5A5_0001 to x7.
   - Required response: with BYPASS=1, rd_data on x7 = 0xA5A5_0001 in the same cycle. With BYPASS=0, the old value in that cycle and the new value the next cycle. Writing 0xFFFF_FFFF to x0 reads back 0.
4. Dual-write collision:
   - Stimulus: port0 writes x3=0x11, port1 writes x3=0x22 in the same cycle.
   - Required response: x3 = 0x22.
5. Scoreboard:
   - Stimulus: sb_set x9.
   - Required response: rd_busy=1 next cycle. A write to x9 gives rd_busy=0 in that cycle (BYPASS) and busy cleared after. A simultaneous set and write on x9 leaves busy=1. sb_set x0 never shows busy.
6. Multi-port read:
   - Stimulus: NRD=3; read x1, x2 and x0 while port1 writes x2=0x55.
   - Required response: rd_data = {0, 0x55, old x1}.

Source files
------------

// File: rtl/reg_file_pkg.sv
// Shared definitions for the multi-port register file.
// Contents:
//   rf_state_e - clear/ready state of the register file controller
//   slice_lo   - low bit index of port 'idx' in a packed bus of 'width'-bit fields
package reg_file_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } rf_state_e;

    function automatic int slice_lo(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/reg_sb.sv
// Per-register busy scoreboard for hazard detection.
// Ports:
//   clk, reset   - rising-edge clock, synchronous active-high reset (clears all busy bits)
//   enable       - updates are accepted only while high (register file ready)
//   wr_en/addr   - writeback ports; each enabled write clears busy[addr]
//   sb_set_en    - issue of a new producer; sets busy[sb_set_addr]
//   rd_addr      - packed read addresses
//   rd_busy      - raw busy bit looked up for each read address
module reg_sb import reg_file_pkg::*; #(
    parameter int NREGS    = 32,
    parameter int NRD      = 2,
    parameter int NWR      = 2,
    parameter int AW       = 5,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [NWR-1:0]    wr_en,
    input  logic [NWR*AW-1:0] wr_addr,
    input  logic              sb_set_en,
    input  logic [AW-1:0]     sb_set_addr,
    input  logic [NRD*AW-1:0] rd_addr,
    output logic [NRD-1:0]    rd_busy
);

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;

    // Clears are applied before the set so that a producer issued in the
    // same cycle as an older producer's writeback keeps the register busy.
    always_comb begin
        busy_d = busy_q;
        for (int j = 0; j < NWR; j++) begin
            if (wr_en[j]) begin
                busy_d[wr_addr[slice_lo(j, AW) +: AW]] = 1'b0;
            end
        end
        if (sb_set_en) begin
            busy_d[sb_set_addr] = 1'b1;
        end
        if (ZERO_REG != 0) begin
            busy_d[0] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q <= '0;
        end else if (enable) begin
            busy_q <= busy_d;
        end
    end

    always_comb begin
        rd_busy = '0;
        for (int i = 0; i < NRD; i++) begin
            rd_busy[i] = busy_q[rd_addr[slice_lo(i, AW) +: AW]];
        end
    end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port integer register file with hardwired zero, optional
// write-to-read bypass, busy scoreboard and a counter-driven clear after reset.
// Ports:
//   clk, reset   - rising-edge clock, synchronous active-high reset
//   init_done    - high once every register has been cleared
//   rd_addr      - NRD packed read addresses
//   rd_data      - NRD packed read results (combinational)
//   rd_busy      - NRD scoreboard flags for the read addresses (combinational)
//   wr_en/addr/data - NWR write ports, highest index wins on collisions
//   sb_set_en/addr  - mark a destination register as pending
module reg_file_mp import reg_file_pkg::*; #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int NRD      = 2,
    parameter int NWR      = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    localparam int AW      = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                reset,
    output logic                init_done,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic [NWR-1:0]      wr_en,
    input  logic [NWR*AW-1:0]   wr_addr,
    input  logic [NWR*XLEN-1:0] wr_data,
    input  logic                sb_set_en,
    input  logic [AW-1:0]       sb_set_addr
);

    rf_state_e        state_q, state_d;
    logic [AW-1:0]    cnt_q, cnt_d;
    logic             ready;
    logic [XLEN-1:0]  mem [NREGS];
    logic [NRD-1:0]   sb_busy;

    logic [AW-1:0]    ra;
    logic [XLEN-1:0]  rv;
    logic             rb;
    logic             hit;

    // Clear sequencer: walks the counter across every register once, then
    // parks in READY until the next reset.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == ST_CLEAR) begin
            cnt_d = cnt_q + AW'(1);
            if (cnt_q == AW'(NREGS - 1)) begin
                state_d = ST_READY;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ready     = (state_q == ST_READY);
    assign init_done = ready;

    // The array has no reset so it can map onto RAM-like storage; the clear
    // sequence writes one zero per cycle instead. Later write ports override
    // earlier ones through non-blocking ordering.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (!ready) begin
                mem[cnt_q] <= '0;
            end else begin
                for (int j = 0; j < NWR; j++) begin
                    if (wr_en[j] &&
                        !(ZERO_REG != 0 && wr_addr[slice_lo(j, AW) +: AW] == AW'(0))) begin
                        mem[wr_addr[slice_lo(j, AW) +: AW]] <= wr_data[slice_lo(j, XLEN) +: XLEN];
                    end
                end
            end
        end
    end

    reg_sb #(
        .NREGS    (NREGS),
        .NRD      (NRD),
        .NWR      (NWR),
        .AW       (AW),
        .ZERO_REG (ZERO_REG)
    ) u_sb (
        .clk         (clk),
        .reset       (reset),
        .enable      (ready),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .sb_set_en   (sb_set_en),
        .sb_set_addr (sb_set_addr),
        .rd_addr     (rd_addr),
        .rd_busy     (sb_busy)
    );

    // Read muxing. A bypassed write also hides the busy flag, unless a new
    // producer for the same register is issued in that very cycle.
    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        ra      = '0;
        rv      = '0;
        rb      = 1'b0;
        hit     = 1'b0;
        for (int i = 0; i < NRD; i++) begin
            ra  = rd_addr[slice_lo(i, AW) +: AW];
            rv  = mem[ra];
            rb  = sb_busy[i];
            hit = 1'b0;
            if (BYPASS != 0) begin
                for (int j = 0; j < NWR; j++) begin
                    if (wr_en[j] && wr_addr[slice_lo(j, AW) +: AW] == ra) begin
                        rv  = wr_data[slice_lo(j, XLEN) +: XLEN];
                        hit = 1'b1;
                    end
                end
                if (hit && !(sb_set_en && sb_set_addr == ra)) begin
                    rb = 1'b0;
                end
            end
            if (ZERO_REG != 0 && ra == AW'(0)) begin
                rv = '0;
                rb = 1'b0;
            end
            if (!ready) begin
                rv = '0;
                rb = 1'b0;
            end
            rd_data[slice_lo(i, XLEN) +: XLEN] = rv;
            rd_busy[i]                         = rb;
        end
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// Self-checking bench for reg_file_mp: a bypassing and a non-bypassing
// instance share all inputs and are compared every cycle against a
// behavioural model, plus directed literal checks.
module tb_reg_file_mp;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NRD   = 3;
    localparam int NWR   = 2;
    localparam int AW    = 5;

    logic                clk;
    logic                reset;
    logic [NRD*AW-1:0]   rd_addr;
    logic [NWR-1:0]      wr_en;
    logic [NWR*AW-1:0]   wr_addr;
    logic [NWR*XLEN-1:0] wr_data;
    logic                sb_set_en;
    logic [AW-1:0]       sb_set_addr;

    logic                init_done_b, init_done_n;
    logic [NRD*XLEN-1:0] rd_data_b, rd_data_n;
    logic [NRD-1:0]      rd_busy_b, rd_busy_n;

    int n_compared   = 0;
    int n_mismatched = 0;

    reg_file_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR),
                  .ZERO_REG(1), .BYPASS(1)) u_byp (
        .clk(clk), .reset(reset), .init_done(init_done_b),
        .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .sb_set_en(sb_set_en), .sb_set_addr(sb_set_addr)
    );

    reg_file_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR),
                  .ZERO_REG(1), .BYPASS(0)) u_nob (
        .clk(clk), .reset(reset), .init_done(init_done_n),
        .rd_addr(rd_addr), .rd_data(rd_data_n), .rd_busy(rd_busy_n),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .sb_set_en(sb_set_en), .sb_set_addr(sb_set_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: architectural register contents, pending flags and
    // the number of registers cleared so far.
    logic [XLEN-1:0] mem_m [NREGS];
    bit              busy_m [NREGS];
    bit              ready_m     = 1'b0;
    int              clr_m       = 0;
    bit              model_valid = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            ready_m     <= 1'b0;
            clr_m       <= 0;
            model_valid <= 1'b1;
            for (int r = 0; r < NREGS; r++) busy_m[r] <= 1'b0;
        end else if (!ready_m) begin
            mem_m[clr_m] <= '0;
            clr_m        <= clr_m + 1;
            if (clr_m == NREGS - 1) ready_m <= 1'b1;
        end else begin
            for (int j = 0; j < NWR; j++) begin
                if (wr_en[j]) begin
                    if (wr_addr[j*AW +: AW] != 0) mem_m[wr_addr[j*AW +: AW]] <= wr_data[j*XLEN +: XLEN];
                    busy_m[wr_addr[j*AW +: AW]] <= 1'b0;
                end
            end
            if (sb_set_en) busy_m[sb_set_addr] <= 1'b1;
            busy_m[0] <= 1'b0;
        end
    end

    function automatic logic [XLEN-1:0] expData(input bit byp, input int addr);
        logic [XLEN-1:0] v;
        if (!ready_m || addr == 0) return '0;
        v = mem_m[addr];
        if (byp) begin
            for (int j = 0; j < NWR; j++) begin
                if (wr_en[j] && int'(wr_addr[j*AW +: AW]) == addr) v = wr_data[j*XLEN +: XLEN];
            end
        end
        return v;
    endfunction

    function automatic logic expBusy(input bit byp, input int addr);
        bit written;
        if (!ready_m || addr == 0) return 1'b0;
        written = 1'b0;
        for (int j = 0; j < NWR; j++) begin
            if (wr_en[j] && int'(wr_addr[j*AW +: AW]) == addr) written = 1'b1;
        end
        if (byp && written && !(sb_set_en && int'(sb_set_addr) == addr)) return 1'b0;
        return busy_m[addr];
    endfunction

    task automatic checkOutput(input string name, input logic [127:0] actual,
                               input logic [127:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // Continuous comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (model_valid) begin
            checkOutput("init_done_byp", 128'(init_done_b), 128'(ready_m));
            checkOutput("init_done_nob", 128'(init_done_n), 128'(ready_m));
            for (int i = 0; i < NRD; i++) begin
                checkOutput($sformatf("rd_data_byp[%0d]", i), 128'(rd_data_b[i*XLEN +: XLEN]),
                            128'(expData(1'b1, int'(rd_addr[i*AW +: AW]))));
                checkOutput($sformatf("rd_data_nob[%0d]", i), 128'(rd_data_n[i*XLEN +: XLEN]),
                            128'(expData(1'b0, int'(rd_addr[i*AW +: AW]))));
                checkOutput($sformatf("rd_busy_byp[%0d]", i), 128'(rd_busy_b[i]),
                            128'(expBusy(1'b1, int'(rd_addr[i*AW +: AW]))));
                checkOutput($sformatf("rd_busy_nob[%0d]", i), 128'(rd_busy_n[i]),
                            128'(expBusy(1'b0, int'(rd_addr[i*AW +: AW]))));
            end
        end
    end

    // One call = one clock cycle of stimulus, driven just after the edge.
    task automatic applyStimulus(input logic rst, input logic [NWR-1:0] we,
                                 input logic [NWR*AW-1:0] wa, input logic [NWR*XLEN-1:0] wd,
                                 input logic se, input logic [AW-1:0] sa,
                                 input logic [NRD*AW-1:0] ra);
        @(posedge clk);
        #1;
        reset       = rst;
        wr_en       = we;
        wr_addr     = wa;
        wr_data     = wd;
        sb_set_en   = se;
        sb_set_addr = sa;
        rd_addr     = ra;
    endtask

    task automatic idle(input logic [NRD*AW-1:0] ra);
        applyStimulus(1'b0, '0, '0, '0, 1'b0, '0, ra);
    endtask

    // Counts posedges until init_done rises; held write/set inputs are
    // dropped the moment READY is reached so nothing lands afterwards.
    task automatic waitInit(input string name);
        int k;
        k = 0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #1;
            if (init_done_b) begin
                k = c;
                break;
            end
        end
        wr_en     = '0;
        sb_set_en = 1'b0;
        checkOutput(name, 128'(k), 128'(32));
    endtask

    task automatic checkAllZero(input string name);
        logic [NRD*AW-1:0] ra;
        for (int base = 0; base < NREGS; base += NRD) begin
            for (int p = 0; p < NRD; p++) ra[p*AW +: AW] = AW'((base + p) % NREGS);
            idle(ra);
            #2;
            for (int p = 0; p < NRD; p++) begin
                checkOutput(name, 128'(rd_data_b[p*XLEN +: XLEN]), 128'(0));
                checkOutput(name, 128'(rd_data_n[p*XLEN +: XLEN]), 128'(0));
            end
        end
    endtask

    initial begin
        reset       = 1'b1;
        wr_en       = '0;
        wr_addr     = '0;
        wr_data     = '0;
        sb_set_en   = 1'b0;
        sb_set_addr = '0;
        rd_addr     = '0;

        // Clear sequence with writes and sets to x5 held throughout.
        for (int c = 0; c < 3; c++) applyStimulus(1'b1, '0, '0, '0, 1'b0, '0, '0);
        applyStimulus(1'b0, 2'b01, {5'd0, 5'd5}, {32'd0, 32'hDEAD}, 1'b1, 5'd5, {5'd0, 5'd0, 5'd5});
        #2;
        checkOutput("clear_rd_zero", 128'(rd_data_b[31:0]), 128'(0));
        checkOutput("clear_busy_zero", 128'(rd_busy_b), 128'(0));
        waitInit("init_latency");
        checkAllZero("clear_all_zero");
        idle({5'd0, 5'd0, 5'd5});
        #2;
        checkOutput("x5_busy_after_clear", 128'(rd_busy_b[0]), 128'(0));

        // Write and read x7, then x0.
        applyStimulus(1'b0, 2'b01, {5'd0, 5'd7}, {32'd0, 32'hA5A5_0001}, 1'b0, '0, {5'd0, 5'd0, 5'd7});
        #2;
        checkOutput("x7_bypass_same", 128'(rd_data_b[31:0]), 128'(32'hA5A5_0001));
        checkOutput("x7_nobypass_old", 128'(rd_data_n[31:0]), 128'(0));
        idle({5'd0, 5'd0, 5'd7});
        #2;
        checkOutput("x7_byp_next", 128'(rd_data_b[31:0]), 128'(32'hA5A5_0001));
        checkOutput("x7_nob_next", 128'(rd_data_n[31:0]), 128'(32'hA5A5_0001));
        applyStimulus(1'b0, 2'b01, {5'd0, 5'd0}, {32'd0, 32'hFFFF_FFFF}, 1'b0, '0, '0);
        #2;
        checkOutput("x0_write_same", 128'(rd_data_b[31:0]), 128'(0));
        idle('0);
        #2;
        checkOutput("x0_write_next", 128'(rd_data_n[31:0]), 128'(0));

        // Dual write collision on x3.
        applyStimulus(1'b0, 2'b11, {5'd3, 5'd3}, {32'h22, 32'h11}, 1'b0, '0, {5'd0, 5'd0, 5'd3});
        #2;
        checkOutput("x3_collide_byp", 128'(rd_data_b[31:0]), 128'(32'h22));
        idle({5'd0, 5'd0, 5'd3});
        #2;
        checkOutput("x3_collide_nob", 128'(rd_data_n[31:0]), 128'(32'h22));

        // Scoreboard on x9 and x0.
        applyStimulus(1'b0, '0, '0, '0, 1'b1, 5'd9, {5'd0, 5'd0, 5'd9});
        #2;
        checkOutput("x9_busy_not_yet", 128'(rd_busy_b[0]), 128'(0));
        idle({5'd0, 5'd0, 5'd9});
        #2;
        checkOutput("x9_busy_set", 128'({rd_busy_b[0], rd_busy_n[0]}), 128'(2'b11));
        applyStimulus(1'b0, 2'b01, {5'd0, 5'd9}, {32'd0, 32'h99}, 1'b0, '0, {5'd0, 5'd0, 5'd9});
        #2;
        checkOutput("x9_busy_wb_cycle", 128'({rd_busy_b[0], rd_busy_n[0]}), 128'(2'b01));
        idle({5'd0, 5'd0, 5'd9});
        #2;
        checkOutput("x9_busy_cleared", 128'({rd_busy_b[0], rd_busy_n[0]}), 128'(2'b00));
        applyStimulus(1'b0, 2'b10, {5'd9, 5'd0}, {32'h77, 32'd0}, 1'b1, 5'd9, {5'd0, 5'd0, 5'd9});
        idle({5'd0, 5'd0, 5'd9});
        #2;
        checkOutput("x9_set_wins", 128'({rd_busy_b[0], rd_busy_n[0]}), 128'(2'b11));
        applyStimulus(1'b0, '0, '0, '0, 1'b1, 5'd0, '0);
        idle('0);
        #2;
        checkOutput("x0_never_busy", 128'({rd_busy_b[0], rd_busy_n[0]}), 128'(2'b00));

        // Three-port read while port1 writes x2.
        applyStimulus(1'b0, 2'b01, {5'd0, 5'd1}, {32'd0, 32'h1234}, 1'b0, '0, '0);
        applyStimulus(1'b0, 2'b10, {5'd2, 5'd0}, {32'h55, 32'd0}, 1'b0, '0, {5'd0, 5'd2, 5'd1});
        #2;
        checkOutput("multiread_byp", 128'(rd_data_b), {32'd0, 32'd0, 32'h55, 32'h1234});
        checkOutput("multiread_nob", 128'(rd_data_n), {32'd0, 32'd0, 32'h0, 32'h1234});
        idle({5'd0, 5'd2, 5'd1});
        #2;
        checkOutput("multiread_nob_next", 128'(rd_data_n), {32'd0, 32'd0, 32'h55, 32'h1234});

        // Randomised traffic; narrow address ranges provoke collisions.
        for (int c = 0; c < 700; c++) begin
            logic [NRD*AW-1:0]   ra;
            logic [NWR*AW-1:0]   wa;
            logic [NWR*XLEN-1:0] wd;
            for (int p = 0; p < NRD; p++) ra[p*AW +: AW] = AW'($urandom_range(0, ($urandom_range(0, 1) != 0) ? 7 : 31));
            for (int j = 0; j < NWR; j++) begin
                wa[j*AW +: AW]     = AW'($urandom_range(0, ($urandom_range(0, 1) != 0) ? 7 : 31));
                wd[j*XLEN +: XLEN] = $urandom;
            end
            applyStimulus(($urandom_range(0, 249) == 0), NWR'($urandom), wa, wd,
                          ($urandom_range(0, 2) == 0), AW'($urandom_range(0, 7)), ra);
        end

        // Reset at clear cycle 10, then a full clear again.
        applyStimulus(1'b1, '0, '0, '0, 1'b0, '0, '0);
        idle('0);
        for (int c = 0; c < 9; c++) idle('0);
        applyStimulus(1'b1, '0, '0, '0, 1'b0, '0, '0);
        #2;
        checkOutput("midclear_init_low", 128'(init_done_b), 128'(0));
        idle('0);
        waitInit("midclear_init_latency");
        checkAllZero("midclear_all_zero");

        idle('0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
